// File: rtl/jtag_scan_pkg.sv
// ---------------------------------------------------------------------------
// jtag_scan_pkg
// Shared definitions for the JTAG scan master: command op encodings, the
// controller FSM state type, TAP reset length and the fixed TMS patterns used
// to walk the TAP into and out of Shift-xR.
// ---------------------------------------------------------------------------
package jtag_scan_pkg;

    typedef enum logic [1:0] {
        OpScanDr     = 2'd0,
        OpScanIr     = 2'd1,
        OpTapReset   = 2'd2,
        OpIdleCycles = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRstSeq,
        StPre,
        StShift,
        StPost,
        StResp
    } state_e;

    // Five TMS=1 cycles reach Test-Logic-Reset from any state; one more
    // TMS=0 cycle parks the TAP in Run-Test/Idle.
    localparam int unsigned TapResetLen = 5;
    localparam int unsigned RstSeqLen   = TapResetLen + 1;

    // TMS patterns, bit 0 is sent first. From Run-Test/Idle to Shift-xR.
    localparam logic [3:0]  PreDrTms = 4'b0001;
    localparam int unsigned PreDrLen = 3;
    localparam logic [3:0]  PreIrTms = 4'b0011;
    localparam int unsigned PreIrLen = 4;

    // From Exit1-xR through Update-xR back to Run-Test/Idle.
    localparam logic [1:0]  PostTms = 2'b01;
    localparam int unsigned PostLen = 2;

    // Where a command continues once the TAP is known to be in Run-Test/Idle.
    function automatic state_e after_reset_state(op_e op, logic len_zero);
        if (op == OpTapReset) begin
            return StResp;
        end
        if (op == OpIdleCycles) begin
            return len_zero ? StResp : StShift;
        end
        return StPre;
    endfunction

endpackage

// File: rtl/jtag_scan_tck_gen.sv
// ---------------------------------------------------------------------------
// jtag_scan_tck_gen
// TCK generator. While enabled, tck is low for CLK_DIV clks then high for
// CLK_DIV clks. Strobes mark the clk whose edge drives tck 0->1 (rise) or
// 1->0 (fall). Disabled: tck held at 0 and the divider restarts, so the first
// enabled cycle always begins with a full low phase.
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_en         run the generator
//   o_tck        JTAG clock
//   o_rise_pulse single-clk strobe, tck goes high at the end of this clk
//   o_fall_pulse single-clk strobe, tck goes low at the end of this clk
// ---------------------------------------------------------------------------
module jtag_scan_tck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DivW-1:0] r_div;
    logic            r_tck;
    logic            w_wrap;

    assign w_wrap       = (r_div == DivW'(CLK_DIV - 1));
    assign o_rise_pulse = i_en && w_wrap && !r_tck;
    assign o_fall_pulse = i_en && w_wrap && r_tck;
    assign o_tck        = r_tck;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (!i_en) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (w_wrap) begin
            r_div <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/jtag_scan_master.sv
// ---------------------------------------------------------------------------
// jtag_scan_master
// Host-side JTAG initiator. Accepts one command at a time, walks the TAP
// through an optional reset sequence, then an IR/DR scan or idle cycles, and
// returns captured TDO bits on the response channel.
//   clk, reset_n          system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                0=SCAN_DR 1=SCAN_IR 2=TAP_RESET 3=IDLE_CYCLES
//   cmd_len               scan length or idle count
//   cmd_data              TDI bits, LSB shifted first
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              captured TDO bits, right-aligned
//   tck, tms, tdi, tdo    JTAG pins
// ---------------------------------------------------------------------------
module jtag_scan_master
    import jtag_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned MAX_LEN = 38,
    parameter int unsigned LEN_W   = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    state_e             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
    op_e                r_op;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_rsp_data;
    logic               r_tap_known;
    logic               r_tms;
    logic               r_tdi;

    op_e                w_cmd_op;
    logic [LEN_W-1:0]   w_cmd_len_eff;
    logic               w_accept;
    logic               w_tck_en;
    logic               w_rise;
    logic               w_fall;
    logic [LEN_W-1:0]   w_phase_len;
    logic               w_last;
    op_e                w_op_cur;
    logic [LEN_W-1:0]   w_len_cur;
    logic [MAX_LEN-1:0] w_data_cur;
    logic               w_tms_nxt;
    logic               w_tdi_nxt;

    jtag_scan_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .i_clk        (clk),
        .i_rst_n      (reset_n),
        .i_en         (w_tck_en),
        .o_tck        (tck),
        .o_rise_pulse (w_rise),
        .o_fall_pulse (w_fall)
    );

    assign w_cmd_op = op_e'(cmd_op);
    assign w_accept = cmd_valid && (r_state == StIdle);

    // Scan lengths are forced into 1..MAX_LEN; idle counts pass through raw.
    always_comb begin
        w_cmd_len_eff = cmd_len;
        if (w_cmd_op == OpScanDr || w_cmd_op == OpScanIr) begin
            if (cmd_len == '0) begin
                w_cmd_len_eff = LEN_W'(1);
            end else if (cmd_len > LEN_W'(MAX_LEN)) begin
                w_cmd_len_eff = LEN_W'(MAX_LEN);
            end
        end
    end

    // While idle the command fields are still on the inputs, not latched.
    assign w_op_cur   = (r_state == StIdle) ? w_cmd_op      : r_op;
    assign w_len_cur  = (r_state == StIdle) ? w_cmd_len_eff : r_len;
    assign w_data_cur = (r_state == StIdle) ? cmd_data      : r_data;

    // TCK cycles in the current phase.
    always_comb begin
        w_phase_len = r_len;
        case (r_state)
            StRstSeq: w_phase_len = LEN_W'(RstSeqLen);
            StPre:    w_phase_len = (r_op == OpScanIr) ? LEN_W'(PreIrLen) : LEN_W'(PreDrLen);
            StPost:   w_phase_len = LEN_W'(PostLen);
            default:  w_phase_len = r_len;
        endcase
    end

    assign w_last = (r_cnt == w_phase_len - 1'b1);

    // FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM: next state. Phases advance on the TCK falling edge so every TCK
    // cycle is complete before the next phase starts.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    if (w_cmd_op == OpTapReset || !r_tap_known) begin
                        w_state_nxt = StRstSeq;
                    end else begin
                        w_state_nxt = after_reset_state(w_cmd_op, cmd_len == '0);
                    end
                end
            end
            StRstSeq, StPre, StShift, StPost: begin
                if (w_fall) begin
                    if (w_last) begin
                        w_cnt_nxt = '0;
                        case (r_state)
                            StRstSeq: w_state_nxt = after_reset_state(r_op, r_len == '0);
                            StPre:    w_state_nxt = StShift;
                            StShift:  w_state_nxt = (r_op == OpIdleCycles) ? StResp : StPost;
                            default:  w_state_nxt = StResp;
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        cmd_ready = (r_state == StIdle);
        rsp_valid = (r_state == StResp);
        w_tck_en  = (r_state == StRstSeq) || (r_state == StPre) ||
                    (r_state == StShift)  || (r_state == StPost);
    end

    // TMS/TDI for the TCK cycle that starts at the next edge, derived from
    // the state/count that cycle will run in.
    always_comb begin
        w_tms_nxt = 1'b0;
        w_tdi_nxt = 1'b0;
        case (w_state_nxt)
            StRstSeq: w_tms_nxt = (w_cnt_nxt < LEN_W'(TapResetLen));
            StPre: begin
                w_tms_nxt = (w_op_cur == OpScanIr) ? PreIrTms[w_cnt_nxt[1:0]]
                                                   : PreDrTms[w_cnt_nxt[1:0]];
            end
            StShift: begin
                if (w_op_cur != OpIdleCycles) begin
                    w_tms_nxt = (w_cnt_nxt == w_len_cur - 1'b1);
                    w_tdi_nxt = w_data_cur[w_cnt_nxt];
                end
            end
            StPost:  w_tms_nxt = PostTms[w_cnt_nxt[0]];
            default: w_tms_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= OpScanDr;
            r_len       <= '0;
            r_data      <= '0;
            r_rsp_data  <= '0;
            r_tap_known <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= w_cmd_op;
                r_len      <= w_cmd_len_eff;
                r_data     <= cmd_data;
                r_rsp_data <= '0;
            end
            if (w_accept || w_fall) begin
                r_tms <= w_tms_nxt;
                r_tdi <= w_tdi_nxt;
            end
            if (r_state == StRstSeq && w_fall && w_last) begin
                r_tap_known <= 1'b1;
            end
            if (r_state == StShift && w_rise && r_op != OpIdleCycles) begin
                r_rsp_data[r_cnt] <= tdo;
            end
        end
    end

    assign tms      = r_tms;
    assign tdi      = r_tdi;
    assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_jtag_scan_master.sv
// ---------------------------------------------------------------------------
// tb_jtag_scan_master
// Drives jtag_scan_master against a behavioural IEEE 1149.1 TAP (2-bit IR
// capturing 2'b01, 1-bit bypass DR capturing 0). Expected TMS streams, TDI
// bits, TCK counts, latencies and captured data come from the protocol rules.
// ---------------------------------------------------------------------------
module tb_jtag_scan_master;
    import jtag_scan_pkg::*;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned MAX_LEN = 38;
    localparam int unsigned LEN_W   = 6;
    localparam int          CLK_PER = 10;

    logic               clk       = 1'b0;
    logic               reset_n   = 1'b1;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_op    = 2'd0;
    logic [LEN_W-1:0]   cmd_len   = '0;
    logic [MAX_LEN-1:0] cmd_data  = '0;
    logic               rsp_ready = 1'b0;
    logic               tdo       = 1'b0;
    logic               cmd_ready;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tck;
    logic               tms;
    logic               tdi;

    int n_vec = 0;
    int n_err = 0;
    bit tap_known_m = 1'b0;

    always #(CLK_PER / 2) clk = ~clk;

    jtag_scan_master #(
        .CLK_DIV (CLK_DIV),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    // ---------------- behavioural TAP target ----------------
    typedef enum int {
        TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauDr, TapEx2Dr, TapUpdDr,
        TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauIr, TapEx2Ir, TapUpdIr
    } tap_e;

    tap_e       tap_st = TapShDr;
    logic       byp    = 1'b0;
    logic [1:0] ir_sr  = 2'b00;
    logic [1:0] ir     = 2'b00;

    logic q_tms[$];
    logic q_tdi[$];
    time  q_rise_t[$];

    function automatic tap_e tap_next(tap_e s, logic m);
        case (s)
            TapTlr:   return m ? TapTlr   : TapRti;
            TapRti:   return m ? TapSelDr : TapRti;
            TapSelDr: return m ? TapSelIr : TapCapDr;
            TapCapDr: return m ? TapEx1Dr : TapShDr;
            TapShDr:  return m ? TapEx1Dr : TapShDr;
            TapEx1Dr: return m ? TapUpdDr : TapPauDr;
            TapPauDr: return m ? TapEx2Dr : TapPauDr;
            TapEx2Dr: return m ? TapUpdDr : TapShDr;
            TapUpdDr: return m ? TapSelDr : TapRti;
            TapSelIr: return m ? TapTlr   : TapCapIr;
            TapCapIr: return m ? TapEx1Ir : TapShIr;
            TapShIr:  return m ? TapEx1Ir : TapShIr;
            TapEx1Ir: return m ? TapUpdIr : TapPauIr;
            TapPauIr: return m ? TapEx2Ir : TapPauIr;
            TapEx2Ir: return m ? TapUpdIr : TapShIr;
            default:  return m ? TapSelDr : TapRti;
        endcase
    endfunction

    always @(posedge tck) begin
        q_tms.push_back(tms);
        q_tdi.push_back(tdi);
        q_rise_t.push_back($time);
        case (tap_st)
            TapCapDr: byp <= 1'b0;
            TapShDr:  byp <= tdi;
            TapCapIr: ir_sr <= 2'b01;
            TapShIr:  ir_sr <= {tdi, ir_sr[1]};
            TapUpdIr: ir <= ir_sr;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
    end

    always @(negedge tck) begin
        tdo <= (tap_st == TapShDr) ? byp : ((tap_st == TapShIr) ? ir_sr[0] : 1'b0);
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tap_known_m = 1'b0;
    endtask

    // Issue one command, wait for its response, check everything, consume it.
    task automatic run_cmd(input op_e op, input int len, input logic [MAX_LEN-1:0] data,
                           input int hold_clks);
        bit                 prefix;
        bit                 is_scan;
        bit                 bad;
        int                 le;
        int                 nexp;
        int                 shift_off;
        int                 n;
        int                 rises0;
        logic [127:0]       exp_tms;
        logic [127:0]       got_tms;
        logic [MAX_LEN-1:0] mask;
        logic [MAX_LEN-1:0] exp_rsp;
        logic [MAX_LEN-1:0] got_tdi;
        time                dmin;
        time                dmax;

        is_scan = (op == OpScanDr) || (op == OpScanIr);
        prefix  = !tap_known_m || (op == OpTapReset);
        le      = len;
        if (is_scan) begin
            if (le == 0) le = 1;
            else if (le > MAX_LEN) le = MAX_LEN;
        end

        exp_tms = '0;
        nexp    = 0;
        if (prefix) begin
            for (int i = 0; i < 6; i++) begin
                exp_tms[nexp] = (i < 5);
                nexp++;
            end
        end
        if (op == OpScanDr) begin
            exp_tms[nexp] = 1'b1;
            nexp += 3;
        end else if (op == OpScanIr) begin
            exp_tms[nexp]     = 1'b1;
            exp_tms[nexp + 1] = 1'b1;
            nexp += 4;
        end
        shift_off = nexp;
        if (op != OpTapReset) nexp += le;
        if (is_scan) begin
            exp_tms[nexp - 1] = 1'b1;
            exp_tms[nexp]     = 1'b1;
            nexp += 2;
        end

        mask = (le >= int'(MAX_LEN)) ? '1 : ((MAX_LEN'(1) << le) - MAX_LEN'(1));
        exp_rsp = '0;
        if (op == OpScanDr) exp_rsp = (data << 1) & mask;
        else if (op == OpScanIr) exp_rsp = ((data << 2) | MAX_LEN'(1)) & mask;

        q_tms.delete();
        q_tdi.delete();
        q_rise_t.delete();
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;

        n = 0;
        while (rsp_valid !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check("rsp_latency", n, 2 * CLK_DIV * nexp);
        check("tck_rises", q_tms.size(), nexp);

        got_tms = '0;
        for (int i = 0; i < q_tms.size() && i < 128; i++) got_tms[i] = q_tms[i];
        check("tms_seq", got_tms, exp_tms);

        if (is_scan) begin
            got_tdi = '0;
            for (int i = 0; i < le; i++) begin
                if (shift_off + i < q_tdi.size()) got_tdi[i] = q_tdi[shift_off + i];
            end
            check("tdi_bits", got_tdi, data & mask);
        end

        if (q_rise_t.size() >= 2) begin
            dmin = q_rise_t[1] - q_rise_t[0];
            dmax = dmin;
            for (int i = 1; i + 1 < q_rise_t.size(); i++) begin
                if (q_rise_t[i + 1] - q_rise_t[i] < dmin) dmin = q_rise_t[i + 1] - q_rise_t[i];
                if (q_rise_t[i + 1] - q_rise_t[i] > dmax) dmax = q_rise_t[i + 1] - q_rise_t[i];
            end
            check("tck_period_min", dmin, 2 * CLK_DIV * CLK_PER);
            check("tck_period_max", dmax, 2 * CLK_DIV * CLK_PER);
        end

        check("rsp_data", rsp_data, exp_rsp);
        check("tap_state", tap_st, TapRti);
        check("cmd_ready_busy", cmd_ready, 1'b0);
        check("tck_low_resp", tck, 1'b0);
        tap_known_m = 1'b1;

        if (hold_clks > 0) begin
            rises0    = q_tms.size();
            bad       = 1'b0;
            cmd_op    = OpTapReset;
            cmd_len   = '0;
            cmd_valid = 1'b1;
            for (int i = 0; i < hold_clks; i++) begin
                tick();
                if (tck !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1 ||
                    rsp_data !== exp_rsp) bad = 1'b1;
            end
            cmd_valid = 1'b0;
            check("hold_quiet", bad, 1'b0);
            check("hold_no_tck", q_tms.size(), rises0);
        end

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("cmd_ready_after_rsp", cmd_ready, 1'b1);
        check("rsp_valid_after_rsp", rsp_valid, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [MAX_LEN-1:0] rdata;
        op_e                rop;
        int                 rlen;

        #2 reset_n = 1'b0;
        repeat (3) tick();
        check("reset_tck", tck, 1'b0);
        check("reset_tms", tms, 1'b1);
        check("reset_tdi", tdi, 1'b0);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_data", rsp_data, '0);
        reset_n = 1'b1;
        tick();

        // TAP reset only: six cycles, no extra prefix.
        run_cmd(OpTapReset, 0, '0, 0);

        // Fresh out of reset: IR scan gets the reset prefix.
        pulse_reset();
        run_cmd(OpScanIr, 2, MAX_LEN'(2'b10), 0);
        check("ir_reg", ir, 2'b10);

        // Full-length DR scan through bypass, response held off for 20 clks.
        run_cmd(OpScanDr, 38, 38'h2A_5555_AAAA, 20);

        // Reset in the middle of a shift.
        q_tms.delete();
        q_tdi.delete();
        q_rise_t.delete();
        cmd_op    = OpScanDr;
        cmd_len   = LEN_W'(38);
        cmd_data  = 38'h15_0F0F_3C3C;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (60) tick();
        check("rises_before_reset", q_tms.size(), 15);
        reset_n = 1'b0;
        #1;
        check("midrst_tck", tck, 1'b0);
        check("midrst_tms", tms, 1'b1);
        check("midrst_tdi", tdi, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_cmd_ready", cmd_ready, 1'b1);
        check("midrst_rsp_data", rsp_data, '0);
        tap_known_m = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        run_cmd(OpScanDr, 5, MAX_LEN'(5'b10110), 0);

        // Length boundaries.
        run_cmd(OpScanDr, 0, MAX_LEN'(1), 0);
        run_cmd(OpIdleCycles, 0, '0, 0);
        run_cmd(OpIdleCycles, 3, '0, 0);
        run_cmd(OpScanIr, 63, 38'h3F_FFFF_FFFF, 0);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 7) == 0) pulse_reset();
            rop   = op_e'(2'($urandom_range(0, 3)));
            rlen  = (rop == OpIdleCycles) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 63));
            rdata = MAX_LEN'({$urandom(), $urandom()});
            run_cmd(rop, rlen, rdata, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Host-side JTAG initiator. Drives TCK/TMS/TDI, samples TDO, and walks an IEEE 1149.1 TAP through IR and DR scans on command.
- It is the opposite end of the CPU's virtual-JTAG debug port. It lets on-chip logic, or a simulation bench, issue debug-module IR/DR scans without an external cable.
- Sits in the clk domain. Commands and responses use valid/ready handshakes.

Parameters:
- CLK_DIV, 2, clk cycles per TCK half period (must be >= 2).
- MAX_LEN, 38, maximum scan length in bits (matches the 38-bit debug data register).
- LEN_W, 6, width of the cmd_len field.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, command accepted when both valid and ready are high
- cmd_op  in  2  0=SCAN_DR, 1=SCAN_IR, 2=TAP_RESET, 3=IDLE_CYCLES
- cmd_len  in  LEN_W  scan length, or idle count for op 3
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  MAX_LEN  captured TDO bits, right-aligned
- tck  out  1  JTAG clock
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to target
- tdo  in  1  JTAG data from target

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0. Internal tap_known=0.
- TCK timing:
  - One TCK cycle is 2*CLK_DIV clks: low for CLK_DIV, then high for CLK_DIV.
  - tms/tdi update only on the clk that drives tck 1->0, or on the first clk after command accept.
  - tdo is sampled on the clk that drives tck 0->1.
  - tck stays 0 whenever the block is idle.
- FSM states: IDLE, RST_SEQ, PRE, SHIFT, POST, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch op/len/data and drop cmd_ready.
  - If tap_known=0 and op!=TAP_RESET, go to RST_SEQ first, then continue with the command.
- RST_SEQ: 5 TCK cycles with tms=1, then 1 with tms=0. Ends in Run-Test/Idle and sets tap_known=1.
- PRE: tms sequence 1,0,0 for DR; 1,1,0,0 for IR. Ends in Shift-xR.
- SHIFT:
  - len TCK cycles. tdi = data[i]; tms=0 except tms=1 on the last bit (enters Exit1).
  - TDO sample i is written to rsp_data[i]; bits >= len are 0.
- POST: tms 1 (Update), then 0 (Run-Test/Idle).
- IDLE_CYCLES: len TCK cycles with tms=0. len=0 means no TCK activity.
- Op completion order:
  - TAP_RESET performs RST_SEQ only.
  - All ops end in RESP. Non-scan ops return rsp_data=0.
- RESP:
  - rsp_valid rises the clk after the last TCK falling edge and holds until rsp_ready.
  - No TCK toggles while in RESP.
  - cmd_ready rises the clk after rsp accept.
- TCK counts: SCAN_DR totals len+5 TCK cycles; SCAN_IR totals len+6. Add 6 if RST_SEQ was prefixed.
- Length rules: for SCAN ops, len=0 is treated as 1 and len>MAX_LEN is clamped to MAX_LEN.
- cmd_valid while cmd_ready=0 is ignored; no queueing.
- reset_n asserted mid-operation: outputs return to reset values immediately, tap_known is cleared, and the in-flight command is dropped with no response.

Decomposition:
- Package jtag_scan_pkg holds:
  - the op encodings;
  - the FSM state enum;
  - the TAP reset length (5);
  - the PRE/POST tms patterns.
- Sub-module jtag_scan_tck_gen holds the CLK_DIV counter and the tck register. It emits single-clk fall_pulse and rise_pulse strobes to the FSM and runs only when enabled.

Test Plan:
- CLK_DIV=2, TAP_RESET -> tms=1,1,1,1,1,0 on six tck rises, each 4 clks apart; rsp_valid with rsp_data=0; cmd_ready back after rsp accept.
- Fresh out of reset, SCAN_IR len=2 data=2'b10 against the bench TAP model -> 6 RST_SEQ cycles, then tms=1,1,0,0,0,1,1,0 with tdi=0,1 on the shift bits; model IR=2'b10; rsp_data=2'b01 (capture pattern).
- SCAN_DR len=38 data=38'h2A_5555_AAAA through a 1-bit bypass register (captures 0) -> rsp_data = (data<<1) & 38'h3F_FFFF_FFFF; exactly 43 tck cycles.
- rsp_ready held low 20 clks after completion -> rsp_valid and rsp_data stable, tck=0, cmd_ready=0; second cmd_valid ignored until after accept.
- reset_n pulsed low mid-SHIFT -> tck=0, tms=1, rsp_valid=0 within the same cycle; next SCAN_DR is preceded by a 6-cycle reset sequence.
- SCAN_DR len=0 -> one shift bit (6 tck cycles); IDLE_CYCLES len=0 -> no tck edges, rsp_valid 1 clk after accept.
